// File: rtl/cell_plotter.sv
// Cell-to-pixel expander: takes one grid cell per valid/ready handshake and emits a
// CELL_W x CELL_W block of pixel writes. Optional grid overlay: define CELL_PLOTTER_GRID_EN.
module cell_plotter #(
  parameter int         COLS        = 40,
  parameter int         ROWS        = 30,
  parameter int         CELL_W      = 4,
  parameter int         X_W         = 8,
  parameter int         Y_W         = 7,
  parameter logic [2:0] LIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR = 3'b000,
  parameter logic [2:0] GRID_COLOUR = 3'b010
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4:0]     in_row,
  input  logic [5:0]     in_col,
  input  logic           in_alive,
  input  logic           in_last,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           writeEn,
  output logic           range_err,
  output logic           frame_done,
  output logic           fsm_state
);

  // Handshake: a cell transfers on a rising clk edge where in_valid and in_ready are both 1;
  // in_ready is registered, low for the whole PAINT burst, and in_* are ignored while it is low.

  localparam int S_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam logic [S_W-1:0] S_MAX = S_W'(CELL_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PAINT = 1'b1
  } state_e;

  state_e         state, state_n;
  logic [4:0]     row_q, row_n;
  logic [5:0]     col_q, col_n;
  logic           alive_q, alive_n;
  logic           last_q, last_n;
  logic [S_W-1:0] sx, sx_n;
  logic [S_W-1:0] sy, sy_n;
  logic [X_W-1:0] x_n;
  logic [Y_W-1:0] y_n;
  logic [2:0]     colour_n;
  logic           we_n, rerr_n, fd_n, ready_n;
  logic           accept, in_range;

  function automatic logic [2:0] pix_colour(input logic alive,
                                            input logic [S_W-1:0] px,
                                            input logic [S_W-1:0] py);
`ifdef CELL_PLOTTER_GRID_EN
    if (px == '0 || py == '0) return GRID_COLOUR;
`endif
    return alive ? LIVE_COLOUR : DEAD_COLOUR;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_range  = (int'(in_row) < ROWS) && (int'(in_col) < COLS);
  assign fsm_state = (state == PAINT);

  always_comb begin
    state_n  = state;
    row_n    = row_q;
    col_n    = col_q;
    alive_n  = alive_q;
    last_n   = last_q;
    sx_n     = sx;
    sy_n     = sy;
    x_n      = x;
    y_n      = y;
    colour_n = colour;
    we_n     = 1'b0;
    rerr_n   = 1'b0;
    fd_n     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          row_n   = in_row;
          col_n   = in_col;
          alive_n = in_alive;
          last_n  = in_last;
          if (in_range) begin
            state_n = PAINT;
            sx_n    = '0;
            sy_n    = '0;
            we_n    = 1'b1;
          end else begin
            // Dropped cell: no pixels and no frame_done, even when it was flagged last.
            rerr_n = 1'b1;
          end
        end
      end
      PAINT: begin
        if (sx == S_MAX && sy == S_MAX) begin
          state_n = IDLE;
          fd_n    = last_q;
        end else begin
          we_n = 1'b1;
          if (sx == S_MAX) begin
            sx_n = '0;
            sy_n = sy + 1'b1;
          end else begin
            sx_n = sx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so the pixel for (sx_n, sy_n) is computed one cycle ahead.
    if (we_n) begin
      x_n      = X_W'(col_n) * X_W'(CELL_W) + X_W'(sx_n);
      y_n      = Y_W'(row_n) * Y_W'(CELL_W) + Y_W'(sy_n);
      colour_n = pix_colour(alive_n, sx_n, sy_n);
    end

    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      alive_q    <= 1'b0;
      last_q     <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      writeEn    <= 1'b0;
      range_err  <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_n;
      row_q      <= row_n;
      col_q      <= col_n;
      alive_q    <= alive_n;
      last_q     <= last_n;
      sx         <= sx_n;
      sy         <= sy_n;
      x          <= x_n;
      y          <= y_n;
      colour     <= colour_n;
      writeEn    <= we_n;
      range_err  <= rerr_n;
      frame_done <= fd_n;
      in_ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter: reset, single cells, range errors, back-to-back
// streaming and mid-cell reset. Build with CELL_PLOTTER_GRID_EN to check the grid overlay.
module tb_cell_plotter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready;
  logic [4:0] in_row;
  logic [5:0] in_col;
  logic       in_alive, in_last;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, range_err, frame_done, fsm_state;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];

  cell_plotter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_alive  (in_alive),
    .in_last   (in_last),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .writeEn   (writeEn),
    .range_err (range_err),
    .frame_done(frame_done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_colour(input logic alive, input int sx, input int sy);
`ifdef CELL_PLOTTER_GRID_EN
    if (sx == 0 || sy == 0) return 3'b010;
`endif
    return alive ? 3'b111 : 3'b000;
  endfunction

  // Present a cell with in_valid for one accepting edge (caller ensures in_ready is high).
  task automatic send_cell(input int row, input int col, input logic alive, input logic last);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_row   = 5'(row);
    in_col   = 6'(col);
    in_alive = alive;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(in_ready && !writeEn) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(in_ready && !writeEn)) begin
      errors++;
      $display("FAIL %s_idle_timeout: in_ready=%0b writeEn=%0b, required in_ready=1 writeEn=0",
               name, in_ready, writeEn);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    in_col   = '0;
    in_alive = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({x, y, colour, writeEn, range_err, frame_done, in_ready, fsm_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d colour=%0d we=%0b rerr=%0b fd=%0b rdy=%0b st=%0b, required all 0",
               x, y, colour, writeEn, range_err, frame_done, in_ready, fsm_state);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || writeEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b writeEn=%0b, required 1 and 0", in_ready, writeEn);
    end
  endtask

  // Paint one in-range cell and check every pixel plus the gap cycle after it.
  task automatic test_cell(input string name, input int row, input int col,
                           input logic alive, input logic last);
    int fd_seen;
    fd_seen = 0;
    send_cell(row, col, alive, last);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (writeEn !== 1'b1 || in_ready !== 1'b0 ||
          x !== 8'(col * 4 + i % 4) || y !== 7'(row * 4 + i / 4) ||
          colour !== exp_colour(alive, i % 4, i / 4)) begin
        errors++;
        $display("FAIL %s_pix%0d: we=%0b rdy=%0b x=%0d y=%0d c=%0d, required we=1 rdy=0 x=%0d y=%0d c=%0d",
                 name, i, writeEn, in_ready, x, y, colour,
                 col * 4 + i % 4, row * 4 + i / 4, exp_colour(alive, i % 4, i / 4));
      end
      if (frame_done) fd_seen++;
    end
    @(negedge clk);
    checks++;
    if (writeEn !== 1'b0 || in_ready !== 1'b1 || frame_done !== last || fd_seen != 0) begin
      errors++;
      $display("FAIL %s_end: we=%0b rdy=%0b fd=%0b early_fd=%0d, required we=0 rdy=1 fd=%0b early_fd=0",
               name, writeEn, in_ready, frame_done, fd_seen, last);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || x !== 8'(col * 4 + 3) || y !== 7'(row * 4 + 3)) begin
      errors++;
      $display("FAIL %s_hold: fd=%0b x=%0d y=%0d, required fd=0 x=%0d y=%0d",
               name, frame_done, x, y, col * 4 + 3, row * 4 + 3);
    end
  endtask

  task automatic test_range_err(input string name, input int row, input int col);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_row   = 5'(row);
    in_col   = 6'(col);
    in_alive = 1'b1;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_row  = 5'd2;
    in_col  = 6'd3;
    in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (range_err !== 1'b1 || writeEn !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: rerr=%0b we=%0b rdy=%0b fd=%0b, required 1 0 1 0",
               name, range_err, writeEn, in_ready, frame_done);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (range_err !== 1'b0 || writeEn !== 1'b1 || x !== 8'd12 || y !== 7'd8) begin
      errors++;
      $display("FAIL %s_next_cell: rerr=%0b we=%0b x=%0d y=%0d, required 0 1 12 8",
               name, range_err, writeEn, x, y);
    end
    wait_idle(name);
  endtask

  task automatic test_back_to_back();
    int rows[3] = '{1, 10, 5};
    int cols[3] = '{2, 20, 39};
    logic alv[3] = '{1'b1, 1'b0, 1'b1};
    int acc_cyc[3];
    int idx, pix_err;
    logic accept, done;
    idx = 0;
    pix_err = 0;
    done = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        exp_q.push_back({8'(cols[k] * 4 + i % 4), 7'(rows[k] * 4 + i / 4),
                         exp_colour(alv[k], i % 4, i / 4)});
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_row = 5'(rows[0]); in_col = 6'(cols[0]); in_alive = alv[0]; in_last = 1'b0;
    for (int c = 0; c < 90 && !done; c++) begin
      @(negedge clk);
      if (writeEn) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_pixel: x=%0d y=%0d, required no write", x, y);
        end else if ({x, y, colour} !== exp_q[0]) begin
          errors++;
          pix_err++;
          $display("FAIL b2b_pixel: got %h, required %h", {x, y, colour}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      accept = in_valid && in_ready;
      if (accept) begin
        acc_cyc[idx] = c;
        idx++;
      end
      @(posedge clk); #1;
      if (accept) begin
        if (idx < 3) begin
          in_row = 5'(rows[idx]); in_col = 6'(cols[idx]); in_alive = alv[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      done = (idx == 3) && (exp_q.size() == 0);
    end
    checks++;
    if (idx != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_complete: accepted=%0d pending=%0d, required 3 and 0", idx, exp_q.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 17 || acc_cyc[2] - acc_cyc[1] != 17) begin
        errors++;
        $display("FAIL b2b_spacing: gaps %0d %0d, required 17 17",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    exp_q.delete();
    in_valid = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    send_cell(3, 4, 1'b1, 1'b1);
    repeat (7) @(negedge clk);
    checks++;
    if (writeEn !== 1'b1 || x !== 8'd18 || y !== 7'd13) begin
      errors++;
      $display("FAIL midrst_7th_pixel: we=%0b x=%0d y=%0d, required 1 18 13", writeEn, x, y);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({x, y, colour, writeEn, range_err, frame_done, in_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: x=%0d y=%0d c=%0d we=%0b rerr=%0b fd=%0b rdy=%0b, required all 0",
               x, y, colour, writeEn, range_err, frame_done, in_ready);
    end
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%0b, required 1", in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done || writeEn) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d cycles with writeEn/frame_done, required 0", bad);
    end
  endtask

  task automatic test_grid();
    int n_grid, n_live;
    n_grid = 0;
    n_live = 0;
    send_cell(7, 11, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (writeEn && colour == 3'b010) n_grid++;
      if (writeEn && colour == 3'b111) n_live++;
    end
    checks++;
`ifdef CELL_PLOTTER_GRID_EN
    if (n_grid != 7 || n_live != 9) begin
      errors++;
      $display("FAIL grid_counts: grid=%0d live=%0d, required 7 9", n_grid, n_live);
    end
`else
    if (n_grid != 0 || n_live != 16) begin
      errors++;
      $display("FAIL grid_counts: grid=%0d live=%0d, required 0 16", n_grid, n_live);
    end
`endif
    wait_idle("grid");
  endtask

  initial begin
    test_reset();
    test_cell("cell_origin", 0, 0, 1'b1, 1'b0);
    test_cell("cell_corner", 29, 39, 1'b0, 1'b1);
    test_cell("cell_mid", 17, 22, 1'b1, 1'b0);
    test_range_err("rerr_row", 30, 5);
    test_range_err("rerr_col", 4, 40);
    test_back_to_back();
    test_reset_mid();
    test_grid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
